// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - ID/EX operand stage signal bundle
// master drives decoded ID fields, forwarding sources and pipeline control; slave is the stage.
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic                      id_alu_src;
  logic [OPCODE_LENGTH-1:0]  id_alu_op;
  logic                      id_reg_write;
  logic                      id_mem_read;

  logic                      exmem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] exmem_rd;
  logic [DATA_WIDTH-1:0]     exmem_result;
  logic                      memwb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] memwb_rd;
  logic [DATA_WIDTH-1:0]     memwb_data;

  logic                      stall_in;
  logic                      flush;

  logic [DATA_WIDTH-1:0]     SrcA;
  logic [DATA_WIDTH-1:0]     SrcB;
  logic [OPCODE_LENGTH-1:0]  Operation;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic                      ex_valid;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      hazard_stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_alu_op, id_reg_write, id_mem_read,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
           stall_in, flush,
    input  SrcA, SrcB, Operation, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, hazard_stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_alu_op, id_reg_write, id_mem_read,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
           stall_in, flush,
    output SrcA, SrcB, Operation, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, hazard_stall
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with forwarding and ALU operand select
// Load-use hazards insert a bubble; external flush beats stall beats hazard.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic               clk,
  input logic               reset,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      alu_src;
    logic [OPCODE_LENGTH-1:0]  alu_op;
    logic                      reg_write;
    logic                      mem_read;
  } stage_t;

  stage_t stage_d;
  stage_t stage_q;
  stage_t id_fields;

  logic                  hazard;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  always_comb begin
    id_fields           = '0;
    id_fields.valid     = bus.id_valid;
    id_fields.rs1       = bus.id_rs1;
    id_fields.rs2       = bus.id_rs2;
    id_fields.rd        = bus.id_rd;
    id_fields.rs1_data  = bus.id_rs1_data;
    id_fields.rs2_data  = bus.id_rs2_data;
    id_fields.imm       = bus.id_imm;
    id_fields.alu_src   = bus.id_alu_src;
    id_fields.alu_op    = bus.id_alu_op;
    id_fields.reg_write = bus.id_reg_write;
    id_fields.mem_read  = bus.id_mem_read;
  end

  // Conservative: rs2 match stalls even when SrcB will take the immediate.
  always_comb begin
    hazard = stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) && bus.id_valid &&
             ((stage_q.rd == bus.id_rs1) || (stage_q.rd == bus.id_rs2));
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = '0;
    end else if (bus.stall_in) begin
      stage_d = stage_q;
    end else if (hazard) begin
      stage_d = '0;
    end else begin
      stage_d = id_fields;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_a = stage_q.rs1_data;
    if (bus.exmem_reg_write && (bus.exmem_rd == stage_q.rs1) && (stage_q.rs1 != '0)) begin
      fwd_a = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd == stage_q.rs1) && (stage_q.rs1 != '0)) begin
      fwd_a = bus.memwb_data;
    end
  end

  always_comb begin
    fwd_b = stage_q.rs2_data;
    if (bus.exmem_reg_write && (bus.exmem_rd == stage_q.rs2) && (stage_q.rs2 != '0)) begin
      fwd_b = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd == stage_q.rs2) && (stage_q.rs2 != '0)) begin
      fwd_b = bus.memwb_data;
    end
  end

  assign bus.SrcA          = fwd_a;
  assign bus.SrcB          = stage_q.alu_src ? stage_q.imm : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.Operation     = stage_q.alu_op;
  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_reg_write  = stage_q.reg_write & stage_q.valid;
  assign bus.ex_mem_read   = stage_q.mem_read & stage_q.valid;
  assign bus.hazard_stall  = hazard;

endmodule
